pipeline_hazard_controller: RTL

Sequences the 5-stage ARM pipeline around the decode stage. Keeps a registered scoreboard of the instructions in EXE and MEM and raises `hazard` on read-after-write conflicts. Raises `flush` when EXE resolves a taken branch. Runs a wait-state FSM that freezes the whole pipeline while a data-memory access completes. Sits beside ID; its outputs drive the ID control gating, the pipeline register enables and the IF/ID flush.

---
 rtl/pipeline_hazard_controller_pkg.sv | 29 ++
 rtl/pipeline_hazard_controller_if.sv | 26 ++
 rtl/pipeline_hazard_controller_compare.sv | 33 +++
 rtl/pipeline_hazard_controller.sv | 98 +++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the decode-stage hazard controller: scoreboard entry layout,
// wait-FSM state encoding and the register-match helper.
package pipeline_hazard_controller_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MAX_WAIT   = 15;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_read;
        logic                  mem_access;
        logic [REG_ADDR_W-1:0] dest;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // True when the entry will write back the register being read.
    function automatic logic entry_hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] src);
        return e.valid & e.wb_en & (e.dest == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ID-stage <-> hazard controller signal bundle.
interface pipeline_hazard_controller_if #(
    parameter int unsigned AW = 4
);
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic          two_src;
    logic          id_wb_en;
    logic          id_mem_read;
    logic          id_mem_write;
    logic [AW-1:0] id_dest;
    logic          branch_taken;
    logic          hazard;
    logic          flush;
    logic          freeze;

    modport master (
        output src1, src2, two_src, id_wb_en, id_mem_read, id_mem_write, id_dest, branch_taken,
        input  hazard, flush, freeze
    );

    modport slave (
        input  src1, src2, two_src, id_wb_en, id_mem_read, id_mem_write, id_dest, branch_taken,
        output hazard, flush, freeze
    );
endinterface

// File: rtl/pipeline_hazard_controller_compare.sv
// Combinational read-after-write check of the ID sources against the EXE/MEM scoreboard.
module hazard_compare
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned FORWARD_EN = 0
) (
    input  logic [REG_ADDR_W-1:0] i_src1,
    input  logic [REG_ADDR_W-1:0] i_src2,
    input  logic                  i_two_src,
    input  sb_entry_t             i_exe,
    input  sb_entry_t             i_mem,
    output logic                  o_raw_hazard
);

    logic w_exe_hit;
    logic w_mem_hit;
    logic w_unused_fields;

    assign w_unused_fields = ^{i_exe.mem_access, i_mem.mem_read, i_mem.mem_access};

    always_comb begin
        w_exe_hit    = entry_hit(i_exe, i_src1) | (i_two_src & entry_hit(i_exe, i_src2));
        w_mem_hit    = entry_hit(i_mem, i_src1) | (i_two_src & entry_hit(i_mem, i_src2));
        o_raw_hazard = 1'b0;
        // With forwarding only a load still in EXE cannot be bypassed in time.
        if (FORWARD_EN != 0) begin
            o_raw_hazard = w_exe_hit & i_exe.mem_read;
        end else begin
            o_raw_hazard = w_exe_hit | w_mem_hit;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage pipeline sequencer: RAW stall, taken-branch flush and data-memory freeze.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned REGFILE_ADDRESS_LEN = REG_ADDR_W,
    parameter int unsigned FORWARD_EN          = 0,
    parameter int unsigned MEM_WAIT_CYCLES     = 0
) (
    input logic                          clk,
    input logic                          rst,
    pipeline_hazard_controller_if.slave  hz
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_WAIT_CYCLES - 1);
    localparam logic             WAIT_EN  = (MEM_WAIT_CYCLES != 0) && (MEM_WAIT_CYCLES <= MAX_WAIT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    sb_entry_t        r_exe;
    sb_entry_t        r_mem;

    logic [REGFILE_ADDRESS_LEN-1:0] w_src1;
    logic [REGFILE_ADDRESS_LEN-1:0] w_src2;
    logic [REGFILE_ADDRESS_LEN-1:0] w_dest;
    sb_entry_t                      w_id_entry;
    logic                           w_raw_hazard;
    logic                           w_freeze;
    logic                           w_flush;
    logic                           w_hazard;

    assign w_src1 = hz.src1;
    assign w_src2 = hz.src2;
    assign w_dest = hz.id_dest;

    always_comb begin
        w_id_entry            = SB_BUBBLE;
        w_id_entry.valid      = 1'b1;
        w_id_entry.wb_en      = hz.id_wb_en;
        w_id_entry.mem_read   = hz.id_mem_read;
        w_id_entry.mem_access = hz.id_mem_read | hz.id_mem_write;
        w_id_entry.dest       = REG_ADDR_W'(w_dest);
    end

    hazard_compare #(
        .FORWARD_EN (FORWARD_EN)
    ) u_compare (
        .i_src1       (REG_ADDR_W'(w_src1)),
        .i_src2       (REG_ADDR_W'(w_src2)),
        .i_two_src    (hz.two_src),
        .i_exe        (r_exe),
        .i_mem        (r_mem),
        .o_raw_hazard (w_raw_hazard)
    );

    // Freeze dominates flush, flush dominates hazard; reset silences all three.
    assign w_freeze  = (r_state == ST_WAIT) & ~rst;
    assign w_flush   = hz.branch_taken & ~w_freeze & ~rst;
    assign w_hazard  = w_raw_hazard & ~w_freeze & ~w_flush & ~rst;

    assign hz.freeze = w_freeze;
    assign hz.flush  = w_flush;
    assign hz.hazard = w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe <= SB_BUBBLE;
            r_mem <= SB_BUBBLE;
        end else if (!w_freeze) begin
            r_mem <= r_exe;
            r_exe <= (w_flush || w_hazard) ? SB_BUBBLE : w_id_entry;
        end
    end

    // Wait-state FSM: freeze starts the cycle after an access moves EXE->MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (WAIT_EN && r_exe.valid && r_exe.mem_access) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
